// File: rtl/lcd_controller.sv
// ============================================================================
// lcd_controller
// ----------------------------------------------------------------------------
// Write-only HD44780 character LCD bus controller. Each write accepted through
// a valid/ready handshake is driven onto the LCD bus as a
// SETUP -> E PULSE -> HOLD -> execution WAIT cycle, with all phases timed by
// a single down-counter.
//
// Optional feature macro: LCD_CONTROLLER_INIT_EN
//   defined   : after reset the controller waits T_POWERUP_CYC cycles and then
//               issues the 8-bit init sequence 0x38,0x38,0x38,0x0C,0x01,0x06
//               before raising init_done and accepting requests.
//   undefined : no POWERUP/INIT states; init_done and req_ready rise on the
//               first clock edge after reset release and software performs
//               the LCD initialisation.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   requester has a write pending
//   req_ready  out  controller accepts a write this cycle (IDLE only)
//   req_rs     in   0 = command register, 1 = data register
//   req_data   in   byte to write
//   init_done  out  power-up init complete, sticky until reset
//   lcd_rs     out  HD44780 register select
//   lcd_rw     out  HD44780 read/write (always 0: write-only)
//   lcd_e      out  HD44780 enable strobe
//   lcd_data   out  HD44780 8-bit data bus
// ============================================================================
module lcd_controller #(
    parameter int T_POWERUP_CYC = 375000,
    parameter int T_SETUP_CYC   = 2,
    parameter int T_PULSE_CYC   = 6,
    parameter int T_HOLD_CYC    = 2,
    parameter int T_EXEC_CYC    = 1000,
    parameter int T_LONG_CYC    = 41000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    // A timing parameter of 0 still occupies one cycle.
    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PU_EFF    = at_least_one(T_POWERUP_CYC);
    localparam int SETUP_EFF = at_least_one(T_SETUP_CYC);
    localparam int PULSE_EFF = at_least_one(T_PULSE_CYC);
    localparam int HOLD_EFF  = at_least_one(T_HOLD_CYC);
    localparam int EXEC_EFF  = at_least_one(T_EXEC_CYC);
    localparam int LONG_EFF  = at_least_one(T_LONG_CYC);

    localparam int MAX_CYC = max_of(max_of(max_of(PU_EFF, SETUP_EFF), max_of(PULSE_EFF, HOLD_EFF)),
                                     max_of(EXEC_EFF, LONG_EFF));
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef logic [CW-1:0] cnt_t;

    // A phase of N cycles loads N-1 on entry and ends on the edge where the
    // counter is already 0.
    localparam cnt_t SETUP_LOAD = cnt_t'(SETUP_EFF - 1);
    localparam cnt_t PULSE_LOAD = cnt_t'(PULSE_EFF - 1);
    localparam cnt_t HOLD_LOAD  = cnt_t'(HOLD_EFF - 1);
    localparam cnt_t EXEC_LOAD  = cnt_t'(EXEC_EFF - 1);
    localparam cnt_t LONG_LOAD  = cnt_t'(LONG_EFF - 1);

    typedef enum logic [2:0] {
`ifdef LCD_CONTROLLER_INIT_EN
        POWERUP,
        INIT,
`endif
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

`ifdef LCD_CONTROLLER_INIT_EN
    localparam state_t RESET_STATE = POWERUP;
    // The cycle between reset release and the first edge counts as the first
    // POWERUP cycle, and the first edge spends one more loading the counter.
    localparam cnt_t   PU_LOAD     = cnt_t'((PU_EFF >= 2) ? (PU_EFF - 2) : 0);

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            3'd3:             return 8'h0C;  // display on, cursor off
            3'd4:             return 8'h01;  // clear display
            3'd5:             return 8'h06;  // entry mode: increment, no shift
            default:          return 8'h00;
        endcase
    endfunction

    logic       pu_loaded_q;
    logic [2:0] init_idx_q;   // index of the next init byte to send
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   cnt_done;
    logic   accept;
    logic   is_long_cmd;

    assign cnt_done = (cnt_q == '0);
    assign accept   = req_valid && req_ready;
    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    assign is_long_cmd = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03);

    assign lcd_rw = 1'b0;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // ----------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef LCD_CONTROLLER_INIT_EN
            POWERUP: if (pu_loaded_q ? cnt_done : (PU_EFF <= 1)) state_d = SETUP;
            INIT:    state_d = SETUP;
`endif
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (cnt_done) state_d = PULSE;
            PULSE:   if (cnt_done) state_d = HOLD;
            HOLD:    if (cnt_done) state_d = WAIT;
            WAIT: begin
                if (cnt_done) begin
`ifdef LCD_CONTROLLER_INIT_EN
                    state_d = (init_done || init_idx_q == 3'd6) ? IDLE : INIT;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // --------------------------------------------------------- phase timer
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                SETUP:   cnt_d = SETUP_LOAD;
                PULSE:   cnt_d = PULSE_LOAD;
                HOLD:    cnt_d = HOLD_LOAD;
                WAIT:    cnt_d = is_long_cmd ? LONG_LOAD : EXEC_LOAD;
                default: cnt_d = '0;
            endcase
        end else if (!cnt_done) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
`ifdef LCD_CONTROLLER_INIT_EN
        if (state_q == POWERUP && !pu_loaded_q && state_d == POWERUP) cnt_d = PU_LOAD;
`endif
    end

    // ------------------------------------------------- datapath / status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            init_done <= 1'b0;
`ifdef LCD_CONTROLLER_INIT_EN
            pu_loaded_q <= 1'b0;
            init_idx_q  <= 3'd0;
`endif
        end else begin
            cnt_q <= cnt_d;
            // Bus value is captured at acceptance and held through HOLD, so
            // later changes on req_rs/req_data cannot disturb the write.
            if (accept) begin
                lcd_rs   <= req_rs;
                lcd_data <= req_data;
            end
`ifdef LCD_CONTROLLER_INIT_EN
            if (state_q == POWERUP) pu_loaded_q <= 1'b1;
            if ((state_q == POWERUP || state_q == INIT) && state_d == SETUP) begin
                lcd_rs     <= 1'b0;
                lcd_data   <= init_byte(init_idx_q);
                init_idx_q <= init_idx_q + 3'd1;
            end
            if (state_q == WAIT && state_d == IDLE) init_done <= 1'b1;
`else
            init_done <= 1'b1;
`endif
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        lcd_e     = (state_q == PULSE);
        req_ready = (state_q == IDLE) && init_done;
    end

endmodule

// File: tb/tb_lcd_controller.sv
// ============================================================================
// tb_lcd_controller
// ----------------------------------------------------------------------------
// Directed self-checking bench for lcd_controller with short timing values
// (POWERUP=100, SETUP=2, PULSE=6, HOLD=2, EXEC=20, LONG=50). Works with the
// design built with or without LCD_CONTROLLER_INIT_EN.
// Latencies are counted in rising edges from the accepting edge up to the
// first edge at which req_ready is 1 again, i.e. the next edge that could
// accept a write.
// ============================================================================
module tb_lcd_controller;

    localparam int PU = 100;
    localparam int SU = 2;
    localparam int PW = 6;
    localparam int HD = 2;
    localparam int EX = 20;
    localparam int LG = 50;

    localparam int LAT_SHORT = SU + PW + HD + EX + 1;  // 31
    localparam int LAT_LONG  = SU + PW + HD + LG + 1;  // 61

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_controller #(
        .T_POWERUP_CYC(PU),
        .T_SETUP_CYC  (SU),
        .T_PULSE_CYC  (PW),
        .T_HOLD_CYC   (HD),
        .T_EXEC_CYC   (EX),
        .T_LONG_CYC   (LG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs   (req_rs),
        .req_data (req_data),
        .init_done(init_done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------- bus monitor
    logic [7:0] p_data[$];
    logic       p_rs[$];
    int         p_cyc[$];
    int         p_width[$];
    int         unstable = 0;
    bit         rw_bad = 1'b0;
    bit         ready_early = 1'b0;
    bit         e_prev = 1'b0;
    int         cur_w = 0;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
        if (req_ready === 1'b1 && init_done !== 1'b1) ready_early = 1'b1;
        if (lcd_e === 1'b1) begin
            if (!e_prev) begin
                p_data.push_back(lcd_data);
                p_rs.push_back(lcd_rs);
                p_cyc.push_back(cyc);
                cur_w = 0;
            end else if (lcd_data !== p_data[$] || lcd_rs !== p_rs[$]) begin
                unstable++;
            end
            cur_w++;
        end else if (e_prev) begin
            p_width.push_back(cur_w);
        end
        e_prev = (lcd_e === 1'b1);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------- helpers
    task automatic wait_ready(input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < budget) begin
            @(negedge clk);
            i++;
            if (req_ready === 1'b1) ok = 1'b1;
        end
    endtask

    // Called at a negedge where req_ready is 1: the next posedge accepts.
    task automatic write_and_time(input logic rs, input logic [7:0] d, output int lat, output bit ok);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_data  = ~d;
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 500) begin
            @(negedge clk);
            lat++;
            if (req_ready === 1'b1) ok = 1'b1;
        end
    endtask

    // ---------------------------------------------------- tests
    task automatic test_reset();
        int base;
`ifdef LCD_CONTROLLER_INIT_EN
        req_valid = 1'b1;   // must not be accepted during reset or init
        req_rs    = 1'b1;
        req_data  = 8'hAA;
`else
        req_valid = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (lcd_e !== 1'b0)     begin n_fail++; $display("FAIL reset_lcd_e: got %b expected 0", lcd_e); end
        n_checks++; if (lcd_rs !== 1'b0)    begin n_fail++; $display("FAIL reset_lcd_rs: got %b expected 0", lcd_rs); end
        n_checks++; if (lcd_rw !== 1'b0)    begin n_fail++; $display("FAIL reset_lcd_rw: got %b expected 0", lcd_rw); end
        n_checks++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_lcd_data: got %h expected 00", lcd_data); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        rst_n   = 1'b1;
        rel_cyc = cyc;
`ifndef LCD_CONTROLLER_INIT_EN
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL noinit_ready_before_edge: got %b expected 0", req_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL noinit_init_done: got %b expected 1", init_done); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL noinit_req_ready: got %b expected 1", req_ready); end
        base = p_data.size();
        repeat (40) @(negedge clk);
        n_checks++; if (p_data.size() != base) begin n_fail++; $display("FAIL noinit_no_pulse: got %0d pulses expected 0", p_data.size() - base); end
`else
        base = 0;
`endif
    endtask

`ifdef LCD_CONTROLLER_INIT_EN
    localparam logic [7:0] INIT_EXP [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    localparam int         INIT_GAP [5] = '{31, 31, 31, 31, 61};

    // Called right after reset release; req_valid is held high throughout.
    task automatic test_init_sequence(input int rel);
        int base;
        int n;
        int done_cyc;
        req_valid   = 1'b1;
        req_rs      = 1'b1;
        req_data    = 8'hAA;
        ready_early = 1'b0;
        base        = p_data.size();
        n           = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;   // drop before the edge that could accept it
        done_cyc  = cyc;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_timeout: init_done=%b after %0d cycles expected 1", init_done, n); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_with_done: got %b expected 1", req_ready); end
        n_checks++; if (ready_early)        begin n_fail++; $display("FAIL init_ready_early: got 1 expected 0"); end
        n_checks++;
        if (p_data.size() - base != 6) begin
            n_fail++; $display("FAIL init_pulse_count: got %0d expected 6", p_data.size() - base);
        end else begin
            n_checks++; if (p_cyc[base] - rel != PU + SU) begin n_fail++; $display("FAIL init_first_rise: got %0d expected %0d", p_cyc[base] - rel, PU + SU); end
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (p_data[base+i] !== INIT_EXP[i]) begin n_fail++; $display("FAIL init_byte%0d: got %h expected %h", i, p_data[base+i], INIT_EXP[i]); end
                n_checks++; if (p_rs[base+i] !== 1'b0)          begin n_fail++; $display("FAIL init_rs%0d: got %b expected 0", i, p_rs[base+i]); end
                n_checks++; if (p_width[base+i] != PW)          begin n_fail++; $display("FAIL init_width%0d: got %0d expected %0d", i, p_width[base+i], PW); end
            end
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (p_cyc[base+i+1] - p_cyc[base+i] != INIT_GAP[i]) begin
                    n_fail++; $display("FAIL init_gap%0d: got %0d expected %0d", i, p_cyc[base+i+1] - p_cyc[base+i], INIT_GAP[i]);
                end
            end
            n_checks++; if (done_cyc - p_cyc[base+5] != PW + HD + EX) begin n_fail++; $display("FAIL init_done_time: got %0d expected %0d", done_cyc - p_cyc[base+5], PW + HD + EX); end
        end
        repeat (40) @(negedge clk);
        n_checks++; if (p_data.size() - base != 6) begin n_fail++; $display("FAIL init_no_extra_pulse: got %0d expected 6", p_data.size() - base); end
    endtask
`endif

    task automatic test_single_write();
        int base, uns0, lat;
        bit ok;
        wait_ready(100, ok);
        base = p_data.size();
        uns0 = unstable;
        write_and_time(1'b1, 8'h41, lat, ok);
        n_checks++; if (!ok || lat != LAT_SHORT) begin n_fail++; $display("FAIL single_latency: got %0d (ok=%b) expected %0d", lat, ok, LAT_SHORT); end
        n_checks++;
        if (p_data.size() - base != 1) begin
            n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", p_data.size() - base);
        end else begin
            n_checks++; if (p_data[base] !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h expected 41", p_data[base]); end
            n_checks++; if (p_rs[base] !== 1'b1)    begin n_fail++; $display("FAIL single_rs: got %b expected 1", p_rs[base]); end
            n_checks++; if (p_width[base] != PW)    begin n_fail++; $display("FAIL single_width: got %0d expected %0d", p_width[base], PW); end
        end
        n_checks++; if (unstable != uns0) begin n_fail++; $display("FAIL single_stable: got %0d changes expected 0", unstable - uns0); end
        n_checks++; if (rw_bad)           begin n_fail++; $display("FAIL lcd_rw_constant: got 1 expected 0"); end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } cmd_vec_t;

    task automatic test_command_latency();
        cmd_vec_t vecs[7];
        int base, lat;
        bit ok;
        vecs[0] = '{1'b0, 8'h01, LAT_LONG};
        vecs[1] = '{1'b0, 8'h80, LAT_SHORT};
        vecs[2] = '{1'b0, 8'h02, LAT_LONG};
        vecs[3] = '{1'b0, 8'h03, LAT_LONG};
        vecs[4] = '{1'b0, 8'h04, LAT_SHORT};
        vecs[5] = '{1'b1, 8'h01, LAT_SHORT};  // data byte 0x01 is not a clear
        vecs[6] = '{1'b0, 8'h00, LAT_SHORT};
        foreach (vecs[i]) begin
            wait_ready(100, ok);
            base = p_data.size();
            write_and_time(vecs[i].rs, vecs[i].data, lat, ok);
            n_checks++;
            if (!ok || lat != vecs[i].lat) begin
                n_fail++; $display("FAIL cmd_latency rs=%b data=%h: got %0d (ok=%b) expected %0d", vecs[i].rs, vecs[i].data, lat, ok, vecs[i].lat);
            end
            n_checks++;
            if (p_data.size() - base != 1 || p_data[$] !== vecs[i].data || p_rs[$] !== vecs[i].rs) begin
                n_fail++; $display("FAIL cmd_pulse rs=%b data=%h: got %0d pulses last %b/%h", vecs[i].rs, vecs[i].data, p_data.size() - base, p_rs[$], p_data[$]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3];
        int base, idx, n;
        bit ok;
        bytes[0] = 8'h48;
        bytes[1] = 8'h49;
        bytes[2] = 8'h21;
        wait_ready(100, ok);
        base      = p_data.size();
        req_valid = 1'b1;
        idx       = 0;
        n         = 0;
        while (idx < 3 && n < 1000) begin
            if (req_ready === 1'b1) begin
                req_rs   = 1'b1;
                req_data = bytes[idx];
                idx++;
            end else begin
                req_rs   = ~req_rs;
                req_data = 8'(n * 37 + 5);
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        wait_ready(100, ok);
        n_checks++; if (!ok || idx != 3) begin n_fail++; $display("FAIL b2b_timeout: accepted %0d ok=%b expected 3", idx, ok); end
        n_checks++;
        if (p_data.size() - base != 3) begin
            n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 3", p_data.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (p_data[base+i] !== bytes[i] || p_rs[base+i] !== 1'b1 || p_width[base+i] != PW) begin
                    n_fail++; $display("FAIL b2b_byte%0d: got %h rs=%b width=%0d expected %h rs=1 width=%0d", i, p_data[base+i], p_rs[base+i], p_width[base+i], bytes[i], PW);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n, base;
        bit ok;
        wait_ready(100, ok);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (lcd_e !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (lcd_e !== 1'b1) begin n_fail++; $display("FAIL midreset_no_pulse: got %b expected 1", lcd_e); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (lcd_e !== 1'b0)     begin n_fail++; $display("FAIL midreset_lcd_e: got %b expected 0", lcd_e); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", req_ready); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL midreset_init_done: got %b expected 0", init_done); end
        n_checks++; if (lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin n_fail++; $display("FAIL midreset_bus: got %b/%h expected 0/00", lcd_rs, lcd_data); end
        repeat (2) @(negedge clk);
        n_checks++; if (p_width[$] != 2) begin n_fail++; $display("FAIL midreset_truncated_width: got %0d expected 2", p_width[$]); end
        rst_n   = 1'b1;
        rel_cyc = cyc;
`ifdef LCD_CONTROLLER_INIT_EN
        test_init_sequence(rel_cyc);
`else
        @(posedge clk);
        #1;
        n_checks++; if (init_done !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_noinit_ready: got done=%b ready=%b expected 1/1", init_done, req_ready); end
        base = p_data.size();
        repeat (40) @(negedge clk);
        n_checks++; if (p_data.size() != base) begin n_fail++; $display("FAIL midreset_noinit_no_pulse: got %0d expected 0", p_data.size() - base); end
`endif
    endtask

    initial begin
        test_reset();
`ifdef LCD_CONTROLLER_INIT_EN
        test_init_sequence(rel_cyc);
`endif
        test_single_write();
        test_command_latency();
        test_back_to_back();
        test_reset_mid_pulse();
        test_single_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
